rx_serial_8n1: RTL and testbench
================================

RX_SERIAL_8N1 -- requirements
Module: rx_serial_8N1

Interface
REQ-001 Parameter M, default 434, SHALL set clock cycles per bit (50 MHz / 115200 baud); legal range is even values from 8 to 8191.
REQ-002 Parameter N, default 13, SHALL set the bit-timer width; M-1 SHALL fit in N bits.
REQ-003 Port clock, input, 1: the block's one clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port entrada_serial, input, 1: asynchronous 8N1 line; idle high; LSB first.
REQ-006 Port apaga, input, 1: one-cycle consume strobe that clears tem_dado.
REQ-007 Port dados_ascii, output, 8: last correctly framed byte.
REQ-008 Port pronto, output, 1: one-cycle pulse when dados_ascii is updated.
REQ-009 Port tem_dado, output, 1: level; an unconsumed byte is held.
REQ-010 Port erro_quadro, output, 1: one-cycle pulse when the stop bit samples low.
REQ-011 Port sobreposicao, output, 1: sticky overrun flag.
REQ-012 Ports db_estado (output, 4: current state code) and db_tick (output, 1: sample strobe) are debug outputs.

Function
REQ-013 entrada_serial SHALL pass through a 2-FF synchronizer; all logic uses only the synchronized value s_rx.
REQ-014 States and codes: REPOUSO=0, INICIO=1, DADOS=2, PARADA=3, ARMAZENA=4, ESPERA_ALTO=5; db_estado SHALL output this code.
REQ-015 In REPOUSO, a cycle t with s_rx=0 SHALL enter INICIO and clear the bit timer.
REQ-016 INICIO SHALL resample s_rx at t+M/2 (mid start bit); if it is 1, the block SHALL return to REPOUSO with no output pulse (glitch reject); if it is 0, it SHALL enter DADOS.
REQ-017 Data bit i (i=0..7) SHALL be sampled at t+M/2+(i+1)*M and shifted into bit position i.
REQ-018 The stop bit SHALL be sampled at t+M/2+9*M in PARADA.
REQ-019 db_tick SHALL be high exactly in each sample cycle.
REQ-020 If the stop bit is 1, the block SHALL enter ARMAZENA; on the next cycle dados_ascii SHALL load the shift register, pronto and tem_dado SHALL assert, and the block SHALL return to REPOUSO.
REQ-021 If the stop bit is 0, erro_quadro SHALL pulse on the next cycle, dados_ascii and tem_dado SHALL remain unchanged, and the block SHALL enter ESPERA_ALTO.
REQ-022 ESPERA_ALTO SHALL remain until s_rx=1 and then enter REPOUSO (break handling).
REQ-023 Latency: pronto SHALL assert M/2+9*M+1 cycles after the start-edge cycle t.
REQ-024 apaga SHALL clear tem_dado on the next edge; apaga with tem_dado=0 SHALL have no effect.
REQ-025 If apaga and ARMAZENA coincide, the new byte SHALL win and tem_dado SHALL end at 1.
REQ-026 ARMAZENA while tem_dado=1 and apaga=0 SHALL overwrite dados_ascii and set sobreposicao, which SHALL clear only on reset.
REQ-027 A new start edge SHALL be accepted in the first cycle of REPOUSO after ARMAZENA, so back-to-back frames are received with no loss.
REQ-028 The bit timer SHALL count 0..M-1 and wrap to 0; it SHALL be cleared on every entry to INICIO.

Reset
REQ-029 While reset=1, the next edge SHALL set: state REPOUSO, synchronizer FFs 1, shift register 0, dados_ascii 0x00, pronto 0, tem_dado 0, erro_quadro 0, sobreposicao 0, timer 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no pulses; if the line is still low after reset, the block SHALL treat it as a new start edge.

Structure
REQ-031 State codes, the default M and N, and 115200/9600 divisor constants SHALL live in a shared include (serial_consts) that the transmitter also uses.
REQ-032 The bit timer SHALL be a single sub-module, rx_tick_gen, with ports clock, reset, zera, meio_bit (M/2 reached) and fim_bit (M reached); the FSM and datapath SHALL stay in rx_serial_8N1.

Verification (bench uses M=16 except where stated)
REQ-033 Byte 0x55 sent with stop bit 1: pronto SHALL pulse once with dados_ascii=0x55, at 16/2+9*16+1 = 153 cycles after the synchronized start edge; tem_dado SHALL be 1.
REQ-034 Bytes 0xA3 then 0x0F back-to-back, no apaga: both SHALL be received; sobreposicao SHALL be 1 and dados_ascii SHALL be 0x0F.
REQ-035 Byte 0xC4 with stop bit 0, then line held low for 40 cycles: erro_quadro SHALL pulse once, there SHALL be no pronto and dados_ascii SHALL keep its old value; a following 0x31 frame SHALL be received correctly.
REQ-036 Line low for 5 cycles only: the block SHALL return to REPOUSO at the mid-start sample with no pulses.
REQ-037 reset asserted during data bit 4 of a 0x7E frame: all outputs SHALL be 0 on the next edge, with no pronto for that frame.
REQ-038 M=434 at 115200 baud, byte 0x4B sent with the sender's bit period 2% slow: dados_ascii SHALL be 0x4B.

Source files
------------

// File: rtl/serial_consts_pkg.sv
// Shared constants for the 8N1 serial receiver and transmitter: state codes and baud divisors.
// Latency: none (constants only).
// Backpressure: none.
package serial_consts_pkg;

    localparam int DIV_115200 = 434;   // 50 MHz / 115200
    localparam int DIV_9600   = 5208;  // 50 MHz / 9600
    localparam int M_PADRAO   = DIV_115200;
    localparam int N_PADRAO   = 13;

    typedef enum logic [3:0] {
        REPOUSO     = 4'd0,
        INICIO      = 4'd1,
        DADOS       = 4'd2,
        PARADA      = 4'd3,
        ARMAZENA    = 4'd4,
        ESPERA_ALTO = 4'd5
    } estado_t;

endpackage

// File: rtl/rx_tick_gen.sv
// Bit timer: counts 0..M-1 and wraps; zera restarts the count from 0 on the next edge.
// Latency: meio_bit/fim_bit are decoded from the registered count (M/2 and M cycles after zera).
// Backpressure: none; free-running.
module rx_tick_gen #(
    parameter int M = 434,
    parameter int N = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    output logic meio_bit,
    output logic fim_bit
);

    localparam logic [N-1:0] MEIO = N'(M / 2 - 1);
    localparam logic [N-1:0] FIM  = N'(M - 1);

    logic [N-1:0] cont;

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            cont <= '0;
        end else if (cont == FIM) begin
            cont <= '0;
        end else begin
            cont <= cont + 1'b1;
        end
    end

    assign meio_bit = (cont == MEIO);
    assign fim_bit  = (cont == FIM);

endmodule

// File: rtl/rx_serial_8n1.sv
// 8N1 UART receiver with mid-bit sampling, glitch reject, framing-error and overrun reporting.
// Latency: pronto pulses M/2+9*M+1 cycles after the synchronized start edge (plus 2 sync cycles).
// Backpressure: none; an unconsumed byte is overwritten and flagged in sobreposicao.
module rx_serial_8n1
    import serial_consts_pkg::*;
#(
    parameter int M = M_PADRAO,
    parameter int N = N_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       apaga,
    output logic [7:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_quadro,
    output logic       sobreposicao,
    output logic [3:0] db_estado,
    output logic       db_tick
);

    estado_t    estado;
    logic       sinc1;
    logic       s_rx;
    logic [7:0] desloc;
    logic [2:0] n_bit;
    logic       zera;
    logic       meio_bit;
    logic       fim_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1 <= 1'b1;
            s_rx  <= 1'b1;
        end else begin
            sinc1 <= entrada_serial;
            s_rx  <= sinc1;
        end
    end

    // Timer restarts at the start edge and again at mid start bit, so every
    // later wrap (fim_bit) falls in the middle of a bit.
    assign zera = ((estado == REPOUSO) && !s_rx) || ((estado == INICIO) && meio_bit);

    rx_tick_gen #(.M(M), .N(N)) u_tick (
        .clock    (clock),
        .reset    (reset),
        .zera     (zera),
        .meio_bit (meio_bit),
        .fim_bit  (fim_bit)
    );

    assign db_estado = estado;
    assign db_tick   = ((estado == INICIO) && meio_bit) ||
                       (((estado == DADOS) || (estado == PARADA)) && fim_bit);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= REPOUSO;
            desloc       <= 8'h00;
            n_bit        <= 3'd0;
            dados_ascii  <= 8'h00;
            pronto       <= 1'b0;
            tem_dado     <= 1'b0;
            erro_quadro  <= 1'b0;
            sobreposicao <= 1'b0;
        end else begin
            pronto      <= 1'b0;
            erro_quadro <= 1'b0;
            if (apaga && tem_dado) begin
                tem_dado <= 1'b0;
            end
            case (estado)
                REPOUSO: begin
                    if (!s_rx) estado <= INICIO;
                end
                INICIO: begin
                    if (meio_bit) begin
                        if (s_rx) begin
                            estado <= REPOUSO;
                        end else begin
                            estado <= DADOS;
                            n_bit  <= 3'd0;
                        end
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        desloc <= {s_rx, desloc[7:1]};
                        n_bit  <= n_bit + 3'd1;
                        if (n_bit == 3'd7) estado <= PARADA;
                    end
                end
                PARADA: begin
                    if (fim_bit) begin
                        if (s_rx) begin
                            // Load here so pronto is visible during ARMAZENA; the new byte beats apaga.
                            estado      <= ARMAZENA;
                            dados_ascii <= desloc;
                            pronto      <= 1'b1;
                            tem_dado    <= 1'b1;
                            if (tem_dado && !apaga) sobreposicao <= 1'b1;
                        end else begin
                            estado      <= ESPERA_ALTO;
                            erro_quadro <= 1'b1;
                        end
                    end
                end
                ARMAZENA:    estado <= REPOUSO;
                ESPERA_ALTO: if (s_rx) estado <= REPOUSO;
                default:     estado <= REPOUSO;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_serial_8n1.sv
// Self-checking bench for rx_serial_8n1: vector table, corner sequences and random frames vs. a frame-level model.
module tb_rx_serial_8n1;

    localparam int MA    = 16;
    localparam int LAT_A = 2 + MA / 2 + 9 * MA + 1;  // sync FFs + mid start + 9 bits + store
    localparam int PER_B = 443;                      // 434 cycles/bit, sender 2% slow

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic       apaga = 1'b0;

    logic [7:0] dados_a, dados_b;
    logic       pronto_a, tem_a, erro_a, sobre_a, tick_a;
    logic       pronto_b, tem_b, erro_b, sobre_b, tick_b;
    logic [3:0] estado_a, estado_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_idx  = 0;
    int p_cnt = 0, p_cyc = 0, e_cnt = 0, t_cnt = 0;
    int pb_cnt = 0, eb_cnt = 0, tb_cnt = 0;

    always #5 clock = ~clock;

    rx_serial_8n1 #(.M(MA), .N(5)) dut_a (
        .clock(clock), .reset(reset), .entrada_serial(line_a), .apaga(apaga),
        .dados_ascii(dados_a), .pronto(pronto_a), .tem_dado(tem_a), .erro_quadro(erro_a),
        .sobreposicao(sobre_a), .db_estado(estado_a), .db_tick(tick_a)
    );

    rx_serial_8n1 #(.M(434), .N(13)) dut_b (
        .clock(clock), .reset(reset), .entrada_serial(line_b), .apaga(1'b0),
        .dados_ascii(dados_b), .pronto(pronto_b), .tem_dado(tem_b), .erro_quadro(erro_b),
        .sobreposicao(sobre_b), .db_estado(estado_b), .db_tick(tick_b)
    );

    // Event monitor, sampled 1 ns after each rising edge.
    always @(posedge clock) begin
        #1;
        cyc_idx++;
        if (pronto_a) begin
            p_cnt++;
            p_cyc = cyc_idx;
        end
        if (erro_a)   e_cnt++;
        if (tick_a)   t_cnt++;
        if (pronto_b) pb_cnt++;
        if (erro_b)   eb_cnt++;
        if (tick_b)   tb_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends one frame on line_a; sidx is the monitor index of the edge preceding the start bit.
    task automatic send_a(input logic [7:0] d, input logic stop, output int sidx);
        sidx = cyc_idx;
        line_a = 1'b0;
        wait_n(MA);
        for (int i = 0; i < 8; i++) begin
            line_a = d[i];
            wait_n(MA);
        end
        line_a = stop;
        wait_n(MA);
        line_a = 1'b1;
    endtask

    task automatic send_b(input logic [7:0] d);
        line_b = 1'b0;
        wait_n(PER_B);
        for (int i = 0; i < 8; i++) begin
            line_b = d[i];
            wait_n(PER_B);
        end
        line_b = 1'b1;
        wait_n(PER_B);
    endtask

    function automatic logic [31:0] all_outs_a();
        return {15'd0, dados_a, pronto_a, tem_a, erro_a, sobre_a, estado_a, tick_a};
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         gap;
        logic       apaga_after;
        logic [7:0] exp_dados;
        logic       exp_tem;
        logic       exp_sobre;
        int         exp_p;
        int         exp_e;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int sidx, p0, e0, t0;
        logic [7:0] m_dados;
        logic       m_tem, m_sobre;

        tbl[0] = '{8'h55, 1'b1, 0,  4, 1'b0, 8'h55, 1'b1, 1'b0, 1, 0};
        tbl[1] = '{8'hA3, 1'b1, 0,  0, 1'b0, 8'hA3, 1'b1, 1'b1, 1, 0};
        tbl[2] = '{8'h0F, 1'b1, 0,  4, 1'b1, 8'h0F, 1'b0, 1'b1, 1, 0};
        tbl[3] = '{8'hC4, 1'b0, 40, 8, 1'b0, 8'h0F, 1'b0, 1'b1, 0, 1};
        tbl[4] = '{8'h31, 1'b1, 0,  4, 1'b0, 8'h31, 1'b1, 1'b1, 1, 0};

        wait_n(2);
        check("reset_state", all_outs_a(), 32'd0);
        reset = 1'b0;
        wait_n(4);

        for (int r = 0; r < 5; r++) begin
            p0 = p_cnt; e0 = e_cnt; t0 = t_cnt;
            send_a(tbl[r].data, tbl[r].stop, sidx);
            if (tbl[r].low_after > 0) begin
                line_a = 1'b0;
                wait_n(tbl[r].low_after);
                line_a = 1'b1;
            end
            wait_n(tbl[r].gap);
            if (tbl[r].apaga_after) begin
                apaga = 1'b1;
                wait_n(1);
                apaga = 1'b0;
            end
            check($sformatf("tbl%0d_dados", r), dados_a, tbl[r].exp_dados);
            check($sformatf("tbl%0d_tem", r), tem_a, tbl[r].exp_tem);
            check($sformatf("tbl%0d_sobre", r), sobre_a, tbl[r].exp_sobre);
            check($sformatf("tbl%0d_pronto_cnt", r), p_cnt - p0, tbl[r].exp_p);
            check($sformatf("tbl%0d_erro_cnt", r), e_cnt - e0, tbl[r].exp_e);
            check($sformatf("tbl%0d_ticks", r), t_cnt - t0, 10);
            if (tbl[r].exp_p == 1) check($sformatf("tbl%0d_latency", r), p_cyc - sidx, LAT_A);
        end

        // Short low glitch: rejected at the mid-start sample.
        p0 = p_cnt; e0 = e_cnt; t0 = t_cnt;
        line_a = 1'b0;
        wait_n(5);
        line_a = 1'b1;
        wait_n(3);
        check("glitch_in_inicio", estado_a, 32'd1);
        wait_n(20);
        check("glitch_state", estado_a, 32'd0);
        check("glitch_pulses", (p_cnt - p0) + (e_cnt - e0), 32'd0);
        check("glitch_ticks", t_cnt - t0, 32'd1);

        // Reset during data bit 4 of 0x7E, held until the frame is over.
        p0 = p_cnt;
        fork
            send_a(8'h7E, 1'b1, sidx);
            begin
                wait_n(88);
                reset = 1'b1;
                wait_n(1);
                check("reset_mid_frame_outs", all_outs_a(), 32'd0);
                wait_n(80);
                reset = 1'b0;
            end
        join
        wait_n(20);
        check("reset_mid_frame_no_pronto", p_cnt - p0, 32'd0);

        // Line still low when reset releases: taken as a new start edge.
        line_a = 1'b0;
        reset = 1'b1;
        wait_n(2);
        reset = 1'b0;
        wait_n(4);
        check("low_after_reset_inicio", estado_a, 32'd1);
        line_a = 1'b1;
        wait_n(20);
        check("low_after_reset_back", estado_a, 32'd0);

        apaga = 1'b1;
        wait_n(1);
        apaga = 1'b0;
        check("apaga_when_empty", {dados_a, tem_a, sobre_a}, 32'd0);

        // apaga in the same cycle as the store: new byte wins, no overrun.
        send_a(8'h12, 1'b1, sidx);
        wait_n(4);
        fork
            send_a(8'h34, 1'b1, sidx);
            begin
                wait_n(LAT_A - 1);
                apaga = 1'b1;
                wait_n(1);
                apaga = 1'b0;
            end
        join
        wait_n(4);
        check("coincide_dados", dados_a, 32'h34);
        check("coincide_tem", tem_a, 32'd1);
        check("coincide_sobre", sobre_a, 32'd0);

        // Random frames against a frame-level model.
        m_dados = 8'h34; m_tem = 1'b1; m_sobre = 1'b0;
        for (int k = 0; k < 25; k++) begin
            logic [7:0] d;
            logic       st, ap;
            int         gap, ep, ee;
            d   = 8'($urandom);
            st  = ($urandom_range(0, 4) != 0);
            gap = st ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 6));
            ap  = 1'($urandom_range(0, 1));
            ep = 0; ee = 0;
            if (st) begin
                if (m_tem) m_sobre = 1'b1;
                m_tem = 1'b1;
                m_dados = d;
                ep = 1;
            end else begin
                ee = 1;
            end
            if (ap) m_tem = 1'b0;
            p0 = p_cnt; e0 = e_cnt; t0 = t_cnt;
            send_a(d, st, sidx);
            wait_n(gap);
            if (ap) begin
                apaga = 1'b1;
                wait_n(1);
                apaga = 1'b0;
            end
            check($sformatf("rnd%0d_dados", k), dados_a, m_dados);
            check($sformatf("rnd%0d_tem", k), tem_a, m_tem);
            check($sformatf("rnd%0d_sobre", k), sobre_a, m_sobre);
            check($sformatf("rnd%0d_pronto_cnt", k), p_cnt - p0, ep);
            check($sformatf("rnd%0d_erro_cnt", k), e_cnt - e0, ee);
            check($sformatf("rnd%0d_ticks", k), t_cnt - t0, 10);
            if (st) check($sformatf("rnd%0d_latency", k), p_cyc - sidx, LAT_A);
        end

        // M=434 receiver with a 2% slow sender.
        p0 = pb_cnt; e0 = eb_cnt; t0 = tb_cnt;
        send_b(8'h4B);
        wait_n(10);
        check("slow_dados", dados_b, 32'h4B);
        check("slow_pronto_cnt", pb_cnt - p0, 32'd1);
        check("slow_erro_cnt", eb_cnt - e0, 32'd0);
        check("slow_ticks", tb_cnt - t0, 32'd10);
        check("slow_tem_sobre_estado", {tem_b, sobre_b, estado_b}, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
